// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the IF/MEM memory port arbiter.
// master = arbiter side, slave = core pipeline plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              err;
  logic [1:0]        grant;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall, err, grant,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall, err, grant,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with fetch
// starvation protection and a WAIT timeout for a memory that never answers.
//
// state   | meaning
// S_IDLE  | no transfer; arbitrate when any request is high
// S_ISSUE | first mem_en cycle of the granted transfer
// S_WAIT  | further mem_en cycles, timeout counter running
// S_DONE  | mem_en low, winner's ack (and err on timeout) high for one cycle
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master io_bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IF   = 2'b01;
  localparam logic [1:0] G_D    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [1:0]        r_grant;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_starved;
  logic              w_d_wins;
  logic [SC_W-1:0]   w_starve_inc;
  logic [TO_W-1:0]   w_to_next;
  logic              w_timeout;

  assign w_starved    = (r_starve_cnt >= SC_W'(STARVE_MAX));
  assign w_d_wins     = io_bus.d_req & (~w_starved | ~io_bus.if_req);
  assign w_starve_inc = w_starved ? r_starve_cnt : r_starve_cnt + SC_W'(1);
  assign w_to_next    = r_to_cnt + TO_W'(1);
  assign w_timeout    = (r_state == S_WAIT) && (w_to_next == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_to_cnt     <= '0;
      r_grant      <= G_NONE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.if_req | io_bus.d_req) begin
            r_state  <= S_ISSUE;
            r_mem_en <= 1'b1;
            r_to_cnt <= '0;
            if (w_d_wins) begin
              r_grant     <= G_D;
              r_mem_we    <= io_bus.d_we;
              r_mem_be    <= io_bus.d_be;
              r_mem_addr  <= io_bus.d_addr;
              r_mem_wdata <= io_bus.d_wdata;
              // Only a data grant that bypassed a waiting fetch counts toward starvation.
              r_starve_cnt <= io_bus.if_req ? w_starve_inc : '0;
            end else begin
              r_grant      <= G_IF;
              r_mem_we     <= 1'b0;
              r_mem_be     <= 4'hF;
              r_mem_addr   <= io_bus.if_addr;
              r_mem_wdata  <= '0;
              r_starve_cnt <= '0;
            end
          end
        end

        S_ISSUE, S_WAIT: begin
          if (io_bus.mem_ready) begin
            r_state  <= S_DONE;
            r_mem_en <= 1'b0;
            r_to_cnt <= '0;
            r_if_ack <= (r_grant == G_IF);
            r_d_ack  <= (r_grant == G_D);
            if (r_grant == G_IF) begin
              r_if_rdata <= io_bus.mem_rdata;
            end else if (!r_mem_we) begin
              r_d_rdata <= io_bus.mem_rdata;
            end
          end else if (w_timeout) begin
            r_state  <= S_DONE;
            r_mem_en <= 1'b0;
            r_to_cnt <= '0;
            r_err    <= 1'b1;
            r_if_ack <= (r_grant == G_IF);
            r_d_ack  <= (r_grant == G_D);
            if (r_grant == G_IF) begin
              r_if_rdata <= '0;
            end else begin
              r_d_rdata <= '0;
            end
          end else begin
            r_state <= S_WAIT;
            if (r_state == S_WAIT) begin
              r_to_cnt <= w_to_next;
            end
          end
        end

        S_DONE: begin
          r_state  <= S_IDLE;
          r_grant  <= G_NONE;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_err    <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_grant  <= G_NONE;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.mem_en    = r_mem_en;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_be    = r_mem_be;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.grant     = r_grant;
  assign io_bus.if_ack    = r_if_ack;
  assign io_bus.d_ack     = r_d_ack;
  assign io_bus.err       = r_err;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.d_rdata   = r_d_rdata;

  // Stalls are forced low while reset is held so the pipeline is not frozen by stale requests.
  assign io_bus.if_stall  = rst & io_bus.if_req & ~r_if_ack;
  assign io_bus.d_stall   = rst & io_bus.d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory commands and
// acks into queues; a memory responder and an ack monitor pop and compare.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;

  typedef struct {
    logic [1:0]  who;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;     // mem_en cycle on which mem_ready is given; 0 = never
    logic [31:0] rdata;
    bit          imm;     // request presented right after the previous ack
  } cmd_t;

  typedef struct {
    logic [1:0]  who;
    logic        err;
    logic [31:0] if_rd;
    logic [31:0] d_rd;
  } ack_t;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_en_cyc  = 0;
  int last_ack_cyc = 0;

  cmd_t cmd_q[$];
  ack_t ack_q[$];

  // reference model state
  int          starve = 0;
  bit          if_pend = 0;
  bit          d_pend  = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_d_rd  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_lat();
    case ($urandom_range(7, 0))
      0:       return 0;
      1:       return TIMEOUT + 1;
      default: return $urandom_range(5, 1);
    endcase
  endfunction

  task automatic start_reqs(input int pct_if, input int pct_d);
    if (!if_pend && $urandom_range(99, 0) < pct_if) begin
      if_pend     = 1;
      bus.if_req  = 1'b1;
      bus.if_addr = 8'($urandom);
    end
    if (!d_pend && $urandom_range(99, 0) < pct_d) begin
      d_pend      = 1;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom);
      bus.d_be    = 4'($urandom);
      bus.d_addr  = 8'($urandom);
      bus.d_wdata = $urandom;
    end
  endtask

  // Predict the next grant from the pending set, queue expectations, wait for the ack,
  // then drop the winner's request at the edge ending DONE.
  task automatic grant_one(input int lat, input logic [31:0] rd, input bit imm);
    cmd_t c;
    ack_t a;
    bit   dw;
    bit   got;
    dw = d_pend && (starve < STARVE_MAX || !if_pend);
    if (dw) begin
      starve  = if_pend ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
      c.who   = 2'b10;
      c.we    = bus.d_we;
      c.be    = bus.d_be;
      c.addr  = bus.d_addr;
      c.wdata = bus.d_wdata;
    end else begin
      starve  = 0;
      c.who   = 2'b01;
      c.we    = 1'b0;
      c.be    = 4'hF;
      c.addr  = bus.if_addr;
      c.wdata = '0;
    end
    c.lat = lat; c.rdata = rd; c.imm = imm;
    if (lat == 0) begin
      if (dw) exp_d_rd = '0; else exp_if_rd = '0;
    end else if (!dw) begin
      exp_if_rd = rd;
    end else if (!c.we) begin
      exp_d_rd = rd;
    end
    a.who = c.who; a.err = (lat == 0); a.if_rd = exp_if_rd; a.d_rd = exp_d_rd;
    cmd_q.push_back(c);
    ack_q.push_back(a);
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = bus.if_ack | bus.d_ack;
    end
    chk("ack_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (dw) begin d_pend = 0; bus.d_req = 1'b0; end
    else    begin if_pend = 0; bus.if_req = 1'b0; end
  endtask

  // memory responder: checks every mem_en cycle against the expected command
  cmd_t rsp_cur;
  int   rsp_n = 0;
  bit   rsp_active = 0;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rsp_active    = 0;
        bus.mem_ready = 1'b0;
      end else if (bus.mem_en) begin
        if (!rsp_active) begin
          if (cmd_q.size() == 0) begin
            chk("unexpected_mem_en", 64'd1, 64'd0);
            rsp_cur = '{who: 2'b00, we: 1'b0, be: 4'h0, addr: 8'h0, wdata: 32'h0,
                        lat: 1, rdata: 32'h0, imm: 1'b0};
          end else begin
            rsp_cur = cmd_q.pop_front();
          end
          rsp_active = 1;
          rsp_n = 0;
          if (rsp_cur.imm) chk("b2b_gap", 64'(cyc - last_ack_cyc), 64'd2);
        end
        rsp_n++;
        last_en_cyc = cyc;
        chk("mem_we",   64'(bus.mem_we),   64'(rsp_cur.we));
        chk("mem_be",   64'(bus.mem_be),   64'(rsp_cur.be));
        chk("mem_addr", 64'(bus.mem_addr), 64'(rsp_cur.addr));
        chk("grant",    64'(bus.grant),    64'(rsp_cur.who));
        if (rsp_cur.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(rsp_cur.wdata));
        if (rsp_cur.lat == rsp_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rsp_cur.rdata;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        if (rsp_active)
          chk("mem_en_cycles", 64'(rsp_n), 64'((rsp_cur.lat == 0) ? TIMEOUT + 1 : rsp_cur.lat));
        rsp_active    = 0;
        bus.mem_ready = 1'($urandom);  // must be ignored outside ISSUE/WAIT
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ack monitor
  ack_t mon_a;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("if_stall", 64'(bus.if_stall), 64'(bus.if_req & ~bus.if_ack));
        chk("d_stall",  64'(bus.d_stall),  64'(bus.d_req & ~bus.d_ack));
        if (bus.if_ack || bus.d_ack) begin
          if (ack_q.size() == 0) begin
            chk("unexpected_ack", 64'd1, 64'd0);
          end else begin
            mon_a = ack_q.pop_front();
            chk("ack_who",     64'({bus.d_ack, bus.if_ack}), 64'(mon_a.who));
            chk("ack_err",     64'(bus.err),      64'(mon_a.err));
            chk("if_rdata",    64'(bus.if_rdata), 64'(mon_a.if_rd));
            chk("d_rdata",     64'(bus.d_rdata),  64'(mon_a.d_rd));
            chk("grant_done",  64'(bus.grant),    64'(mon_a.who));
            chk("mem_en_done", 64'(bus.mem_en),   64'd0);
            chk("ack_latency", 64'(cyc - last_en_cyc), 64'd1);
          end
          last_ack_cyc = cyc;
        end else begin
          chk("err_idle", 64'(bus.err), 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  cmd_t rc;
  bit   gap;
  int   wn;

  initial begin
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 8'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 8'h0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en",   64'(bus.mem_en),    64'd0);
    chk("rst_mem_we",   64'(bus.mem_we),    64'd0);
    chk("rst_mem_be",   64'(bus.mem_be),    64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr),  64'd0);
    chk("rst_wdata",    64'(bus.mem_wdata), 64'd0);
    chk("rst_grant",    64'(bus.grant),     64'd0);
    chk("rst_if_ack",   64'(bus.if_ack),    64'd0);
    chk("rst_d_ack",    64'(bus.d_ack),     64'd0);
    chk("rst_err",      64'(bus.err),       64'd0);
    chk("rst_if_rdata", 64'(bus.if_rdata),  64'd0);
    chk("rst_d_rdata",  64'(bus.d_rdata),   64'd0);
    chk("rst_if_stall", 64'(bus.if_stall),  64'd0);
    chk("rst_d_stall",  64'(bus.d_stall),   64'd0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // single fetch, ready in the first mem_en cycle
    if_pend = 1; bus.if_req = 1'b1; bus.if_addr = 8'h10;
    grant_one(1, 32'h00500093, 0);

    // store with three mem_en cycles, request raised at the edge ending DONE
    d_pend = 1; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 8'h40; bus.d_wdata = 32'hDEADBEEF;
    grant_one(3, 32'h12345678, 1);

    // sustained contention: both requesters always pending, 1-cycle memory
    for (int r = 0; r < 12; r++) begin
      start_reqs(100, 100);
      grant_one(1, $urandom, 1);
    end
    while (if_pend || d_pend) grant_one(1, $urandom, 1);

    // timeout on a load, then a normal fetch
    d_pend = 1; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF;
    bus.d_addr = 8'h84; bus.d_wdata = $urandom;
    grant_one(0, $urandom, 1);
    if_pend = 1; bus.if_req = 1'b1; bus.if_addr = 8'h24;
    grant_one(2, $urandom, 1);

    // randomized traffic
    for (int r = 0; r < 200; r++) begin
      gap = 0;
      if (!if_pend && !d_pend && $urandom_range(3, 0) == 0) begin
        gap = 1;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      start_reqs(60, 60);
      if (!if_pend && !d_pend) start_reqs(100, 0);
      grant_one(pick_lat(), $urandom, !gap);
    end
    while (if_pend || d_pend) grant_one(pick_lat(), $urandom, 1);

    // reset during WAIT of a fetch
    if_pend = 1; bus.if_req = 1'b1; bus.if_addr = 8'($urandom);
    rc = '{who: 2'b01, we: 1'b0, be: 4'hF, addr: bus.if_addr, wdata: 32'h0,
           lat: 0, rdata: 32'h0, imm: 1'b1};
    cmd_q.push_back(rc);
    wn = 0;
    while (!bus.mem_en && wn < 20) begin
      @(negedge clk);
      wn++;
    end
    chk("rst_test_issue", 64'(bus.mem_en), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_en",   64'(bus.mem_en),   64'd0);
    chk("midrst_grant",    64'(bus.grant),    64'd0);
    chk("midrst_if_ack",   64'(bus.if_ack),   64'd0);
    chk("midrst_if_stall", 64'(bus.if_stall), 64'd0);
    cmd_q.delete();
    starve = 0; exp_if_rd = '0; exp_d_rd = '0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    grant_one(2, $urandom, 0);

    repeat (4) @(posedge clk);
    chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
    chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RV32IMC core.
- Sequences each transfer through an issue/wait/complete FSM.
- Produces per-requester acknowledge and stall signals so the pipeline registers can be frozen while a request is outstanding.
- Adds starvation protection for fetch and a timeout for unresponsive memory.

Parameters:
- ADDR_W, 8, memory byte-address width (matches PC width).
- DATA_W, 32, data word width.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT, 15, WAIT cycles without mem_ready before the transfer is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched word, registered.
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables (store).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data, registered.
- d_stall  out  1  d_req & ~d_ack.
- err  out  1  pulses with ack when the transfer timed out.
- mem_en  out  1  memory command valid.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready.
- mem_ready  in  1  memory completion, may assert in the first mem_en cycle.
- grant  out  2  owner: 00 none, 01 IF, 10 data.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 (if_rdata, d_rdata, grant, mem_* included); starvation counter 0; timeout counter 0. A reset mid-transfer abandons it with no ack; mem_en drops immediately.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitration runs when any req is high.
  - Data wins if d_req and (starve_cnt < STARVE_MAX or !if_req); otherwise IF wins.
  - Winner's addr/we/be/wdata are registered into mem_* (IF forces we=0, be=4'hF).
  - grant is set; next state is ISSUE.
- ISSUE / WAIT:
  - mem_en=1 and mem_* held stable.
  - If mem_ready: capture mem_rdata into the winner's rdata register (loads and fetches only; stores leave d_rdata unchanged), go to DONE.
  - Else ISSUE→WAIT, or WAIT stays.
- Timeout: the counter increments in each WAIT cycle. When it reaches TIMEOUT without mem_ready, go to DONE with err set; the winner's rdata is loaded with 0.
- DONE:
  - mem_en=0; winner's ack=1 for exactly this cycle; err=1 only if timed out.
  - Requests are ignored here; next state IDLE, and grant clears to 00.
  - Requesters drop or replace req at the clock edge ending DONE.
- Latency: req sampled in IDLE at cycle 0 → mem_en cycles 1..k → ack at k+1. Minimum is ack at cycle 2 (mem_ready in cycle 1).
- Starvation counter, updated at each grant:
  - Data grant with if_req high: increment, saturating at STARVE_MAX.
  - IF grant, or data grant with if_req low: clear to 0.
- Simultaneous if_req/d_req in IDLE: data wins unless starve_cnt == STARVE_MAX.
- Requests with req low at the IDLE sample are never issued. A req that deasserts before ack is a protocol violation; the in-flight transfer completes regardless.
- Stalls: if_stall and d_stall are combinational (req & ~ack) and are 0 during reset.

Test Plan:
- Single fetch, memory ready in first cycle: if_req=1, if_addr=8'h10, mem_ready in cycle 1, mem_rdata=32'h00500093 → mem_en only in cycle 1; if_ack and if_rdata=32'h00500093 at cycle 2; if_stall high in cycles 0-1.
- Store with a 3-cycle wait: d_req=1, d_we=1, d_be=4'b0011, d_addr=8'h40, d_wdata=32'hDEADBEEF, mem_ready on the 3rd mem_en cycle → mem_* stable for 3 cycles; d_ack one cycle later; d_rdata unchanged; err=0.
- Contention/starvation: if_req and d_req held continuously, each transfer 1-cycle ready, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I…; if_ack never delayed by more than 4 data transfers.
- Timeout: d_req=1 load, mem_ready never asserts, TIMEOUT=15 → d_ack and err pulse together after 15 WAIT cycles; d_rdata=0; the FSM returns to IDLE and the next fetch proceeds normally.
- Reset mid-WAIT: rst=0 during WAIT of a fetch → mem_en, grant and if_ack go 0 immediately. After release with if_req still high, a fresh fetch is issued from IDLE.
- Back-to-back ack/req: the data requester re-asserts a new request at the edge ending DONE while if_req is idle → no request sampled during DONE; the new mem_en appears exactly 2 cycles after the previous ack.
